// File: rtl/periph_bus_arbiter_pkg.sv
// Shared definitions for the peripheral bus arbiter: file-address width and
// the debug-path FSM state encoding.
package periph_bus_arbiter_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage : periph_bus_arbiter_pkg

// File: rtl/periph_bus_arbiter_starve_counter.sv
// Starvation timer for the debug path: loads LIMIT on clear, counts down on
// each starved cycle, flags terminal count when one starved cycle remains.
module arb_starve_counter #(
    parameter int LIMIT = 16,
    parameter int W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = W'(LIMIT);
        end else if (en_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The starved cycle seen while this is high is the LIMIT-th one.
    assign tc_o = (cnt_q == W'(1));

endmodule : arb_starve_counter

// File: rtl/periph_bus_arbiter.sv
// Shares the peripheral bus between the core (absolute priority, combinational
// pass-through) and a debug requester. Optional macro: PERIPH_ARB_ADDR_FILTER_EN.
//
// state  | meaning
// IDLE   | ready for a debug request
// WAIT   | request held, waiting for a cycle with no core strobe
// ACCESS | drive debug access unless the core takes the bus
// DONE   | one-cycle ack, timeout flag qualifies it
module periph_bus_arbiter
    import periph_bus_arbiter_pkg::*;
#(
    parameter int                STARVE_LIMIT = 16,
    parameter logic [ADDR_W-1:0] ADDR_LO      = 9'h000,
    parameter logic [ADDR_W-1:0] ADDR_HI      = 9'h1FF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_rd_en,
    input  logic              core_wr_en,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_timeout,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd_en,
    output logic              bus_wr_en,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255 || ADDR_LO > ADDR_HI) begin : g_bad_param
        $error("periph_bus_arbiter: illegal parameter combination");
    end

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              to_q, to_d;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_tc;
    logic              core_busy;
    logic              addr_ok;

    assign core_busy = core_rd_en | core_wr_en;

`ifdef PERIPH_ARB_ADDR_FILTER_EN
    assign addr_ok = (dbg_addr >= ADDR_LO) && (dbg_addr <= ADDR_HI);
`else
    assign addr_ok = 1'b1;
`endif

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dbg_req) begin
                    we_d    = dbg_we;
                    addr_d  = dbg_addr;
                    wdata_d = dbg_wdata;
                    cnt_clr = 1'b1;
                    to_d    = !addr_ok;
                    state_d = addr_ok ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                if (core_busy) begin
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        to_d    = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (core_busy) begin
                    state_d = ST_WAIT;
                end else begin
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
        end
    end

    // Core always wins; debug strobes only appear in ACCESS with the core idle.
    always_comb begin
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        bus_rd_en = 1'b0;
        bus_wr_en = 1'b0;
        if (core_busy) begin
            bus_addr  = core_addr;
            bus_wdata = core_wdata;
            bus_rd_en = core_rd_en;
            bus_wr_en = core_wr_en;
        end else if (state_q == ST_ACCESS) begin
            bus_rd_en = !we_q;
            bus_wr_en = we_q;
        end
    end

    assign core_rdata  = bus_rdata;
    assign dbg_ready   = (state_q == ST_IDLE);
    assign dbg_ack     = (state_q == ST_DONE);
    assign dbg_timeout = (state_q == ST_DONE) && to_q;
    assign dbg_rdata   = rdata_q;

endmodule : periph_bus_arbiter

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter built with STARVE_LIMIT = 4.
module tb_periph_bus_arbiter;

`ifdef PERIPH_ARB_ADDR_FILTER_EN
    localparam logic [8:0] ADDR_HI_P = 9'h07F;
    localparam logic [8:0] WR_ADDR   = 9'h056;
`else
    localparam logic [8:0] ADDR_HI_P = 9'h1FF;
    localparam logic [8:0] WR_ADDR   = 9'h086;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] core_addr;
    logic       core_rd_en, core_wr_en;
    logic [7:0] core_wdata, core_rdata;
    logic       dbg_req, dbg_we;
    logic [8:0] dbg_addr;
    logic [7:0] dbg_wdata;
    logic       dbg_ready, dbg_ack, dbg_timeout;
    logic [7:0] dbg_rdata;
    logic [8:0] bus_addr;
    logic       bus_rd_en, bus_wr_en;
    logic [7:0] bus_wdata, bus_rdata;

    int checks = 0;
    int errors = 0;

    periph_bus_arbiter #(
        .STARVE_LIMIT (4),
        .ADDR_LO      (9'h000),
        .ADDR_HI      (ADDR_HI_P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core_addr   (core_addr),
        .core_rd_en  (core_rd_en),
        .core_wr_en  (core_wr_en),
        .core_wdata  (core_wdata),
        .core_rdata  (core_rdata),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_ready   (dbg_ready),
        .dbg_ack     (dbg_ack),
        .dbg_rdata   (dbg_rdata),
        .dbg_timeout (dbg_timeout),
        .bus_addr    (bus_addr),
        .bus_rd_en   (bus_rd_en),
        .bus_wr_en   (bus_wr_en),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One debug transaction observed over a fixed 12-cycle window.
    task automatic run_txn(input logic we, input logic [8:0] a, input logic [7:0] wd,
                           input logic [15:0] busy_mask, input logic busy_wr,
                           input logic [15:0] req_mask,
                           output int ack_cnt, output int ack_cyc, output logic to_seen,
                           output int strobe_cnt, output int strobe_cyc,
                           output logic [8:0] strobe_addr, output logic [7:0] strobe_wdata,
                           output logic rdy1);
        ack_cnt = 0; ack_cyc = -1; to_seen = 1'b0;
        strobe_cnt = 0; strobe_cyc = -1; strobe_addr = '0; strobe_wdata = '0; rdy1 = 1'b0;
        dbg_we = we; dbg_addr = a; dbg_wdata = wd;
        for (int c = 0; c < 12; c++) begin
            dbg_req    = req_mask[c];
            core_rd_en = busy_mask[c] && !busy_wr;
            core_wr_en = busy_mask[c] && busy_wr;
            core_addr  = 9'h010;
            core_wdata = 8'h77;
            #2;
            if (c == 1) rdy1 = dbg_ready;
            if (busy_mask[c]) begin
                chk("core_pass_addr", bus_addr, 9'h010);
            end else if (bus_rd_en || bus_wr_en) begin
                strobe_cnt++;
                strobe_cyc   = c;
                strobe_addr  = bus_addr;
                strobe_wdata = bus_wdata;
            end
            if (dbg_ack) begin
                ack_cnt++;
                ack_cyc = c;
                to_seen = dbg_timeout;
            end
            tick();
        end
        dbg_req = 1'b0; core_rd_en = 1'b0; core_wr_en = 1'b0;
    endtask

    int         ack_cnt, ack_cyc, strobe_cnt, strobe_cyc;
    logic       to_seen, rdy1;
    logic [8:0] s_addr;
    logic [7:0] s_wdata;

    initial begin
        rst = 1'b1;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        core_addr = 9'h123; core_rd_en = 1'b1; core_wr_en = 1'b0; core_wdata = 8'h00;
        bus_rdata = 8'h5C;
        #2;
        chk("rst_core_rd", bus_rd_en, 1'b1);
        chk("rst_core_addr", bus_addr, 9'h123);
        chk("core_rdata", core_rdata, 8'h5C);
        tick();
        tick();
        rst = 1'b0; core_rd_en = 1'b0;
        #1;
        chk("rst_ready", dbg_ready, 1'b1);
        chk("rst_ack", dbg_ack, 1'b0);
        chk("rst_timeout", dbg_timeout, 1'b0);
        chk("rst_rdata", dbg_rdata, 8'h00);
        chk("rst_bus_addr", bus_addr, 9'h000);
        chk("rst_bus_wdata", bus_wdata, 8'h00);
        chk("rst_strobes", {bus_rd_en, bus_wr_en}, 2'b00);
        tick();

        // Best-case read
        bus_rdata = 8'hA5;
        run_txn(1'b0, 9'h006, 8'h00, 16'h0000, 1'b0, 16'h0001,
                ack_cnt, ack_cyc, to_seen, strobe_cnt, strobe_cyc, s_addr, s_wdata, rdy1);
        chk("rd_ack_cnt", ack_cnt, 1);
        chk("rd_ack_cyc", ack_cyc, 3);
        chk("rd_timeout", to_seen, 1'b0);
        chk("rd_strobe_cnt", strobe_cnt, 1);
        chk("rd_strobe_cyc", strobe_cyc, 2);
        chk("rd_strobe_addr", s_addr, 9'h006);
        chk("rd_rdata", dbg_rdata, 8'hA5);

        // Write delayed by two core write cycles
        bus_rdata = 8'h11;
        run_txn(1'b1, WR_ADDR, 8'h3C, 16'h0006, 1'b1, 16'h0001,
                ack_cnt, ack_cyc, to_seen, strobe_cnt, strobe_cyc, s_addr, s_wdata, rdy1);
        chk("wr_ack_cnt", ack_cnt, 1);
        chk("wr_ack_cyc", ack_cyc, 5);
        chk("wr_timeout", to_seen, 1'b0);
        chk("wr_strobe_cnt", strobe_cnt, 1);
        chk("wr_strobe_cyc", strobe_cyc, 4);
        chk("wr_strobe_wdata", s_wdata, 8'h3C);
        chk("wr_strobe_addr", s_addr, WR_ADDR);
        chk("wr_rdata_kept", dbg_rdata, 8'hA5);

        // Starvation: core reads continuously, limit 4
        bus_rdata = 8'h5A;
        run_txn(1'b0, 9'h020, 8'h00, 16'h0FFE, 1'b0, 16'h0001,
                ack_cnt, ack_cyc, to_seen, strobe_cnt, strobe_cyc, s_addr, s_wdata, rdy1);
        chk("to_ack_cnt", ack_cnt, 1);
        chk("to_ack_cyc", ack_cyc, 5);
        chk("to_timeout", to_seen, 1'b1);
        chk("to_strobe_cnt", strobe_cnt, 0);
        chk("to_rdata_kept", dbg_rdata, 8'hA5);

        // Second request while in WAIT is ignored
        bus_rdata = 8'h96;
        run_txn(1'b0, 9'h030, 8'h00, 16'h0000, 1'b0, 16'h0003,
                ack_cnt, ack_cyc, to_seen, strobe_cnt, strobe_cyc, s_addr, s_wdata, rdy1);
        chk("dup_ready_wait", rdy1, 1'b0);
        chk("dup_ack_cnt", ack_cnt, 1);
        chk("dup_ack_cyc", ack_cyc, 3);
        chk("dup_strobe_cnt", strobe_cnt, 1);
        chk("dup_rdata", dbg_rdata, 8'h96);

        // Core steals the ACCESS cycle: back to WAIT, retry
        bus_rdata = 8'hC3;
        run_txn(1'b0, 9'h050, 8'h00, 16'h0004, 1'b0, 16'h0001,
                ack_cnt, ack_cyc, to_seen, strobe_cnt, strobe_cyc, s_addr, s_wdata, rdy1);
        chk("steal_ack_cyc", ack_cyc, 5);
        chk("steal_strobe_cyc", strobe_cyc, 4);
        chk("steal_strobe_cnt", strobe_cnt, 1);
        chk("steal_rdata", dbg_rdata, 8'hC3);

        // Reset while in WAIT drops the access; core strobe still passes
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h040; dbg_wdata = 8'hEE;
        tick();
        dbg_req = 1'b0;
        rst = 1'b1; core_wr_en = 1'b1; core_addr = 9'h011; core_wdata = 8'h99;
        #2;
        chk("rstw_ready_before", dbg_ready, 1'b0);
        chk("rstw_core_wr", bus_wr_en, 1'b1);
        chk("rstw_core_wdata", bus_wdata, 8'h99);
        tick();
        rst = 1'b0; core_wr_en = 1'b0;
        #2;
        chk("rstw_ready", dbg_ready, 1'b1);
        chk("rstw_bus_addr", bus_addr, 9'h000);
        ack_cnt = 0;
        strobe_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (dbg_ack) ack_cnt++;
            if (bus_rd_en || bus_wr_en) strobe_cnt++;
            tick();
            #1;
        end
        chk("rstw_no_ack", ack_cnt, 0);
        chk("rstw_no_strobe", strobe_cnt, 0);

        // Out-of-window address (filtered only when the feature is built in)
        bus_rdata = 8'h4B;
        run_txn(1'b0, 9'h0A0, 8'h00, 16'h0000, 1'b0, 16'h0001,
                ack_cnt, ack_cyc, to_seen, strobe_cnt, strobe_cyc, s_addr, s_wdata, rdy1);
        chk("flt_ack_cnt", ack_cnt, 1);
`ifdef PERIPH_ARB_ADDR_FILTER_EN
        chk("flt_ack_cyc", ack_cyc, 1);
        chk("flt_timeout", to_seen, 1'b1);
        chk("flt_strobe_cnt", strobe_cnt, 0);
        chk("flt_rdata_kept", dbg_rdata, 8'hC3);
`else
        chk("flt_ack_cyc", ack_cyc, 3);
        chk("flt_timeout", to_seen, 1'b0);
        chk("flt_strobe_cnt", strobe_cnt, 1);
        chk("flt_rdata", dbg_rdata, 8'h4B);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_periph_bus_arbiter
